// File: rtl/tty_tx_arb_if.sv
// Bundle of the requester byte streams and the tty_tx handshake shared by the
// arbiter (slave side) and the byte sources / transmitter (master side).
`timescale 1ns/1ps
interface tty_tx_arb_if #(
  parameter int N = 4
);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [N-1:0]   gnt;
  logic           timeout;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data, gnt, timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data, gnt, timeout
  );
endinterface

// File: rtl/tty_tx_arb.sv
// Round-robin, packet-locked arbiter in front of a single tty_tx transmitter.
// A one-byte holding register feeds the transmitter so owners may drop valid at
// will; an idle counter reclaims the grant from an owner that stalls mid-packet.
`timescale 1ns/1ps
module tty_tx_arb #(
  parameter int N       = 4,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 16
) (
  input  logic        clk,
  input  logic        rstb,
  tty_tx_arb_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [7:0]      hold_q, hold_d;
  logic            full_q, full_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            to_q, to_d;
  logic            xfer;
  logic [N-1:0]    own_mask;
  int              j;

  // Next round-robin start: the requester after the one just released.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    if (int'(i) == N - 1) return '0;
    return IW'(int'(i) + 1);
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] m;
    m    = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  // Pick the first requesting index starting at ptr and wrapping; scanning
  // from the far end lets the closest requester overwrite the others.
  always_comb begin
    pick     = ptr_q;
    pick_vld = 1'b0;
    j        = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (bus.req_valid[j]) begin
        pick     = IW'(j);
        pick_vld = 1'b1;
      end
    end
  end

  // State register: FSM state plus grant bookkeeping, holding byte and idle counter.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= 8'h00;
      full_q  <= 1'b0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Next-state logic: grant in IDLE, byte capture / packet end / timeout in LOCK.
  // The holding register drains on tx_ready in either state, so a released
  // owner's last byte still goes out while the next owner is being granted.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    xfer    = (state_q == LOCK) && bus.req_valid[owner_q] && (!full_q || bus.tx_ready);

    if (xfer) begin
      hold_d = bus.req_data[8*owner_q +: 8];
      full_d = 1'b1;
    end else if (full_q && bus.tx_ready) begin
      full_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = LOCK;
          owner_d = pick;
          cnt_d   = '0;
        end
      end
      LOCK: begin
        if (xfer) begin
          cnt_d = '0;
          if (bus.req_last[owner_q]) begin
            state_d = IDLE;
            ptr_d   = wrap_inc(owner_q);
          end
        end else if (!full_q && !bus.req_valid[owner_q]) begin
          if (cnt_q == TO_W'(TIMEOUT - 1)) begin
            state_d = IDLE;
            ptr_d   = wrap_inc(owner_q);
            cnt_d   = '0;
            to_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: tx_valid is masked during tx_ready because tty_tx samples valid
  // in its ready cycle; leaving it high there would resend the old byte.
  always_comb begin
    own_mask      = onehot(owner_q);
    bus.gnt       = (state_q == LOCK) ? own_mask : '0;
    bus.req_ready = ((state_q == LOCK) && (!full_q || bus.tx_ready)) ? own_mask : '0;
    bus.tx_valid  = full_q && !bus.tx_ready;
    bus.tx_data   = hold_q;
    bus.timeout   = to_q;
  end
endmodule

// File: tb/tb_tty_tx_arb.sv
// Bench for tty_tx_arb: directed scenarios with literal expectations, then
// randomized traffic checked cycle by cycle against a behavioural model, with
// a tty_tx stand-in that consumes bytes and pulses ready at frame end.
`timescale 1ns/1ps
module tb_tty_tx_arb;
  localparam int N       = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  tty_tx_arb_if #(.N(N)) bus ();

  tty_tx_arb #(.N(N), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_owner;   // -1 when nobody holds the grant
  int          m_ptr;
  int          m_idle;    // consecutive idle cycles seen for the owner
  logic [7:0]  m_hold;
  bit          m_full;
  bit          m_to;
  logic [7:0]  exp_q[$];  // bytes accepted, in the order they must reach the line
  logic [7:0]  rx_log[$]; // bytes the transmitter actually took
  logic [N-1:0] eg, er;
  bit          smp_tx_valid;
  logic [7:0]  smp_tx_data;
  bit          spur_en = 1'b0;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_idle = 0;
    m_hold = 8'h00; m_full = 1'b0; m_to = 1'b0;
    exp_q.delete();
  endtask

  task automatic release_owner();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_idle  = 0;
  endtask

  task automatic model_step();
    bit old_full, rdy, xfer, nto;
    old_full = m_full;
    rdy      = bus.tx_ready;
    xfer     = 1'b0;
    nto      = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && bus.req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      m_idle = 0;
    end else begin
      xfer = bus.req_valid[m_owner] && (!old_full || rdy);
      if (xfer) begin
        m_hold = bus.req_data[8*m_owner +: 8];
        exp_q.push_back(m_hold);
        m_idle = 0;
        if (bus.req_last[m_owner]) release_owner();
      end else if (!old_full && !bus.req_valid[m_owner]) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          release_owner();
          nto = 1'b1;
        end
      end else begin
        m_idle = 0;
      end
    end
    if (xfer) m_full = 1'b1;
    else if (old_full && rdy) m_full = 1'b0;
    m_to = nto;
  endtask

  // Compare process: every cycle, mid-period, DUT outputs versus the model.
  always @(negedge clk) begin
    if (!rstb) model_reset();
    smp_tx_valid = bus.tx_valid;
    smp_tx_data  = bus.tx_data;
    eg = '0;
    er = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (!m_full || bus.tx_ready) er[m_owner] = 1'b1;
    end
    chk("gnt",       bus.gnt,       eg);
    chk("req_ready", bus.req_ready, er);
    chk("tx_valid",  bus.tx_valid,  m_full && !bus.tx_ready);
    chk("tx_data",   bus.tx_data,   m_hold);
    chk("timeout",   bus.timeout,   m_to);
    if (rstb) model_step();
  end

  // ---------------- tty_tx stand-in ----------------
  bit tty_busy;
  int tty_left;
  initial begin
    bus.tx_ready = 1'b0;
    tty_busy = 1'b0;
    tty_left = 0;
    forever begin
      @(posedge clk); #1;
      if (!rstb) begin
        tty_busy = 1'b0;
        bus.tx_ready = 1'b0;
      end else if (bus.tx_ready) begin
        bus.tx_ready = 1'b0;
        tty_busy = 1'b0;
      end else if (tty_busy) begin
        tty_left--;
        if (tty_left == 0) bus.tx_ready = 1'b1;
      end else if (smp_tx_valid) begin
        tty_busy = 1'b1;
        tty_left = $urandom_range(4, 1);
        rx_log.push_back(smp_tx_data);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL tty_byte: got 0x%0h, expected no byte pending", smp_tx_data);
        end else begin
          chk("tty_byte", smp_tx_data, exp_q.pop_front());
        end
      end else if (spur_en && !m_full && $urandom_range(99) < 5) begin
        bus.tx_ready = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int i, input logic [7:0] d, input bit last, input bit v);
    bus.req_valid[i]        = v;
    bus.req_data[8*i +: 8]  = d;
    bus.req_last[i]         = last;
  endtask

  task automatic wait_accept(input int i, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (bus.req_valid[i] && bus.req_ready[i]) ok = 1'b1;
    end
    chk(name, ok, 1'b1);
  endtask

  function automatic logic [31:0] rx_at(input int k);
    if (k < rx_log.size()) return 32'(rx_log[k]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int prob_pick(input int s);
    case (s)
      0: return 0;
      1: return 10;
      2: return 50;
      default: return 90;
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rstb = 1'b0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    rx_log.delete();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ord[$];
    int sent[N];
    int idle;
    int prob[N];
    bit seen;
    logic [N-1:0] acc;

    rstb = 1'b0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_gnt",     bus.gnt,       0);
    chk("rst_ready",   bus.req_ready, 0);
    chk("rst_txvalid", bus.tx_valid,  0);
    chk("rst_txdata",  bus.tx_data,   0);
    chk("rst_timeout", bus.timeout,   0);
    @(posedge clk); #1;
    rstb = 1'b1;

    // Two-byte packet from requester 0
    @(posedge clk); #1;
    drive(0, 8'h41, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_gnt_idle",   bus.gnt,       0);
    chk("t1_ready_idle", bus.req_ready, 0);
    @(negedge clk);
    chk("t1_gnt",   bus.gnt,       4'b0001);
    chk("t1_ready", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    drive(0, 8'h42, 1'b1, 1'b1);
    wait_accept(0, "t1_accept_B");
    @(posedge clk); #1;
    drive(0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_release", bus.gnt, 0);
    repeat (30) @(negedge clk);
    chk("t1_rx_count", rx_log.size(), 2);
    chk("t1_rx0", rx_at(0), 8'h41);
    chk("t1_rx1", rx_at(1), 8'h42);

    // Round robin between two requesters with single-byte packets
    do_reset();
    drive(0, 8'h10, 1'b1, 1'b1);
    drive(1, 8'h20, 1'b1, 1'b1);
    sent[0] = 0; sent[1] = 0;
    for (int c = 0; c < 200 && ord.size() < 4; c++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      for (int i = 0; i < 2; i++) if (acc[i]) begin ord.push_back(i); sent[i]++; end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (sent[i] >= 2) drive(i, 8'h00, 1'b0, 1'b0);
        else drive(i, 8'(8'h10 * (i + 1) + sent[i]), 1'b1, 1'b1);
      end
    end
    chk("t2_count", ord.size(), 4);
    chk("t2_ord0", (ord.size() > 0) ? ord[0] : -1, 0);
    chk("t2_ord1", (ord.size() > 1) ? ord[1] : -1, 1);
    chk("t2_ord2", (ord.size() > 2) ? ord[2] : -1, 0);
    chk("t2_ord3", (ord.size() > 3) ? ord[3] : -1, 1);
    drive(1, 8'h30, 1'b1, 1'b1);
    drive(2, 8'h40, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2_idle", bus.gnt, 0);
    @(negedge clk);
    chk("t2_ptr2_gnt", bus.gnt, 4'b0100);
    wait_accept(2, "t2_accept_r2");
    @(posedge clk); #1;
    drive(2, 8'h00, 1'b0, 1'b0);
    wait_accept(1, "t2_accept_r1");
    @(posedge clk); #1;
    drive(1, 8'h00, 1'b0, 1'b0);
    repeat (20) @(negedge clk);

    // Idle timeout reclaims the grant from a stalled owner
    do_reset();
    drive(0, 8'h55, 1'b0, 1'b1);
    wait_accept(0, "t4_accept");
    @(posedge clk); #1;
    drive(0, 8'h00, 1'b0, 1'b0);
    drive(2, 8'h77, 1'b1, 1'b1);
    idle = 0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (bus.timeout) seen = 1'b1;
      else if (bus.gnt == 4'b0001 && !bus.tx_valid && !bus.tx_ready && !bus.req_valid[0]) idle++;
    end
    chk("t4_pulse",       seen,     1'b1);
    chk("t4_idle_cycles", idle,     16);
    chk("t4_gnt_rel",     bus.gnt,  0);
    @(negedge clk);
    chk("t4_gnt_r2",      bus.gnt,     4'b0100);
    chk("t4_pulse_end",   bus.timeout, 0);
    @(posedge clk); #1;
    drive(2, 8'h00, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    chk("t4_rx_count", rx_log.size(), 2);
    chk("t4_rx0", rx_at(0), 8'h55);
    chk("t4_rx1", rx_at(1), 8'h77);

    // Asynchronous reset in the middle of the second byte's frame
    do_reset();
    drive(3, 8'h31, 1'b0, 1'b1);
    wait_accept(3, "t6_b1");
    @(posedge clk); #1;
    drive(3, 8'h32, 1'b0, 1'b1);
    wait_accept(3, "t6_b2");
    @(posedge clk); #1;
    drive(3, 8'h33, 1'b1, 1'b1);
    for (int c = 0; c < 100 && rx_log.size() < 2; c++) begin
      @(posedge clk); #1;
    end
    chk("t6_second_in_flight", rx_log.size(), 2);
    #2;
    rstb = 1'b0;
    #1;
    chk("t6_async_gnt",     bus.gnt,       0);
    chk("t6_async_ready",   bus.req_ready, 0);
    chk("t6_async_txvalid", bus.tx_valid,  0);
    chk("t6_async_txdata",  bus.tx_data,   0);
    chk("t6_async_timeout", bus.timeout,   0);
    drive(3, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    rx_log.delete();
    drive(3, 8'h61, 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_idle", bus.gnt, 0);
    @(negedge clk);
    chk("t6_gnt3", bus.gnt, 4'b1000);
    @(posedge clk); #1;
    drive(3, 8'h62, 1'b1, 1'b1);
    wait_accept(3, "t6_accept_last");
    @(posedge clk); #1;
    drive(3, 8'h00, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    chk("t6_rx_count", rx_log.size(), 2);
    chk("t6_rx0", rx_at(0), 8'h61);
    chk("t6_rx1", rx_at(1), 8'h62);

    // Randomized traffic with varying activity and stray tx_ready pulses
    spur_en = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (cyc % 64 == 0) for (int i = 0; i < N; i++) prob[i] = prob_pick($urandom_range(3));
      for (int i = 0; i < N; i++)
        drive(i, 8'($urandom), ($urandom_range(2) == 0), ($urandom_range(99) < prob[i]));
    end
    @(posedge clk); #1;
    spur_en = 1'b0;
    bus.req_valid = '0;
    repeat (300) @(negedge clk);
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_gnt",     bus.gnt,      0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
